// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch stage plus IF/ID pipeline register.
//               Holds the PC, issues req/ack reads to instruction memory,
//               buffers one returned word in a skid register while decode
//               is stalled, and applies branch redirects with a flush of all
//               younger fetched work. Produces Opcode/Funct for the main
//               control decoder.
//
// Ports       : clk, rst_n                 clock, async active-low reset
//               imem_req/addr/ack/rdata    instruction memory read channel
//               stall                      decode cannot accept new word
//               redirect_valid/pc          taken-branch redirect from EX
//               id_valid/instr/pc4         IF/ID register contents
//               Opcode, Funct              id_instr[31:26], id_instr[5:0]
//               perf_fetched, perf_stall   only with IFETCH_PERF_EN
//
// Options     : IFETCH_PERF_EN - adds perf_fetched / perf_stall counters.
//
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              id_valid,
  output logic [31:0]       id_instr,
  output logic [ADDR_W-1:0] id_pc4,
`ifdef IFETCH_PERF_EN
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall,
`endif
  output logic [5:0]        Opcode,
  output logic [5:0]        Funct
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,  // request outstanding at pc
    S_SKID  = 2'd1,  // one word buffered, request paused
    S_DRAIN = 2'd2   // stale request in flight, its data will be dropped
  } state_t;

  localparam logic [ADDR_W-1:0] C_FOUR = {{(ADDR_W-3){1'b0}}, 3'b100};

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                req_q, req_d;
  logic                id_valid_q, id_valid_d;
  logic [31:0]         id_instr_q, id_instr_d;
  logic [ADDR_W-1:0]   id_pc4_q, id_pc4_d;
  logic [31:0]         skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0]   skid_pc4_q, skid_pc4_d;

  logic                w_ack;
  logic                w_held;
  logic [ADDR_W-1:0]   w_pc_inc;
  logic [ADDR_W-1:0]   w_redir_pc;
  logic                unused_redir_lsb;

  // An ack is only honoured while a request is actually presented; this
  // also masks the quiet cycle right after reset release.
  assign w_ack      = imem_ack & req_q;
  assign w_held     = id_valid_q & stall;
  assign w_pc_inc   = pc_q + C_FOUR;
  assign w_redir_pc = {redirect_pc[ADDR_W-1:2], 2'b00};

  assign unused_redir_lsb = ^redirect_pc[1:0];

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    id_valid_d   = id_valid_q;
    id_instr_d   = id_instr_q;
    id_pc4_d     = id_pc4_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;

    case (state_q)
      S_FETCH: begin
        if (redirect_valid) begin
          id_valid_d = 1'b0;
          id_instr_d = 32'h0;
          pc_d       = w_redir_pc;
          // A request already on the bus without its ack must complete
          // before the new target can be presented.
          state_d    = (req_q & ~imem_ack) ? S_DRAIN : S_FETCH;
        end else if (w_ack) begin
          pc_d = w_pc_inc;
          if (w_held) begin
            skid_instr_d = imem_rdata;
            skid_pc4_d   = w_pc_inc;
            state_d      = S_SKID;
          end else begin
            id_valid_d = 1'b1;
            id_instr_d = imem_rdata;
            id_pc4_d   = w_pc_inc;
          end
        end else if (!w_held) begin
          id_valid_d = 1'b0;
          id_instr_d = 32'h0;
        end
      end

      S_SKID: begin
        if (redirect_valid) begin
          id_valid_d   = 1'b0;
          id_instr_d   = 32'h0;
          skid_instr_d = 32'h0;
          skid_pc4_d   = {ADDR_W{1'b0}};
          pc_d         = w_redir_pc;
          state_d      = S_FETCH;
        end else if (!stall) begin
          id_valid_d   = 1'b1;
          id_instr_d   = skid_instr_q;
          id_pc4_d     = skid_pc4_q;
          skid_instr_d = 32'h0;
          skid_pc4_d   = {ADDR_W{1'b0}};
          state_d      = S_FETCH;
        end
      end

      S_DRAIN: begin
        id_valid_d = 1'b0;
        id_instr_d = 32'h0;
        if (redirect_valid) begin
          pc_d = w_redir_pc;
        end
        // The stale word is discarded; fetching resumes at the latest target.
        if (w_ack) begin
          state_d = S_FETCH;
        end
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Address is frozen while draining so the bus stays stable until ack.
  assign addr_d = (state_d == S_DRAIN) ? addr_q : pc_d;
  assign req_d  = (state_d != S_SKID);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      req_q        <= 1'b0;
      id_valid_q   <= 1'b0;
      id_instr_q   <= 32'h0;
      id_pc4_q     <= {ADDR_W{1'b0}};
      skid_instr_q <= 32'h0;
      skid_pc4_q   <= {ADDR_W{1'b0}};
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      req_q        <= req_d;
      id_valid_q   <= id_valid_d;
      id_instr_q   <= id_instr_d;
      id_pc4_q     <= id_pc4_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign id_valid  = id_valid_q;
  assign id_instr  = id_instr_q;
  assign id_pc4    = id_pc4_q;
  assign Opcode    = id_instr_q[31:26];
  assign Funct     = id_instr_q[5:0];

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic        w_if_write;

  // Counts only words that actually land in IF/ID; flushed words never do.
  assign w_if_write = ((state_q == S_FETCH) & ~redirect_valid & w_ack & ~w_held) |
                      ((state_q == S_SKID)  & ~redirect_valid & ~stall);

  assign perf_fetched_d = perf_fetched_q + {31'h0, w_if_write};
  assign perf_stall_d   = perf_stall_q + {31'h0, w_held};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= 32'h0;
      perf_stall_q   <= 32'h0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule
`default_nettype wire
